snoop_bus_controller: RTL and testbench

Downstream stage of the per-processor coherence state machine: accepts its bus transaction (bus code, processor index, final state, writeback flag), broadcasts it to every other processor's copy of the tracked block, and applies the remote-side (snoop) MSI transitions. Sequences the needed writebacks to memory over a valid/ready handshake, then commits the requester's final state. Owns the authoritative per-processor state table that feeds `i_state` back upstream.

---
 rtl/coherence_pkg.sv | 26 ++
 rtl/snoop_next_state.sv | 42 ++++
 rtl/snoop_bus_controller.sv | 134 +++++++++++++
 tb/tb_snoop_bus_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
// rtl/coherence_pkg.sv - MSI state, bus, CPU action and bus FSM codes shared by the coherence stages
package coherence_pkg;

  localparam logic [1:0] STATE_INVALID   = 2'b00;
  localparam logic [1:0] STATE_SHARED    = 2'b01;
  localparam logic [1:0] STATE_EXCLUSIVE = 2'b10;

  localparam logic [2:0] BUS_NONE       = 3'b000;
  localparam logic [2:0] BUS_READ_MISS  = 3'b001;
  localparam logic [2:0] BUS_WRITE_MISS = 3'b010;
  localparam logic [2:0] BUS_INVALIDATE = 3'b011;

  localparam logic [2:0] CPU_READ_HIT   = 3'b001;
  localparam logic [2:0] CPU_READ_MISS  = 3'b010;
  localparam logic [2:0] CPU_WRITE_HIT  = 3'b011;
  localparam logic [2:0] CPU_WRITE_MISS = 3'b100;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_SNOOP,
    FSM_WB_REMOTE,
    FSM_WB_REQ,
    FSM_COMMIT
  } bus_fsm_t;

endpackage

// File: rtl/snoop_next_state.sv
// rtl/snoop_next_state.sv - remote-side MSI transition for one snooped copy
module snoop_next_state
  import coherence_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic [2:0] i_bus,
  output logic [1:0] o_next,
  output logic       o_wb,
  output logic       o_illegal
);

  always_comb begin
    o_next    = i_state;
    o_wb      = 1'b0;
    o_illegal = 1'b0;
    case (i_state)
      STATE_SHARED: begin
        if (i_bus == BUS_WRITE_MISS || i_bus == BUS_INVALIDATE) o_next = STATE_INVALID;
      end
      STATE_EXCLUSIVE: begin
        case (i_bus)
          BUS_READ_MISS: begin
            o_next = STATE_SHARED;
            o_wb   = 1'b1;
          end
          BUS_WRITE_MISS: begin
            o_next = STATE_INVALID;
            o_wb   = 1'b1;
          end
          // An exclusive copy cannot coexist with a requester that already holds the block
          BUS_INVALIDATE: begin
            o_next    = STATE_INVALID;
            o_illegal = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// rtl/snoop_bus_controller.sv - broadcasts a bus transaction, applies snoop transitions,
// sequences writebacks and commits the requester's final state
module snoop_bus_controller
  import coherence_pkg::*;
#(
  parameter int NUM_PROC = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [2:0]                  bus,
  input  logic [$clog2(NUM_PROC)-1:0] processor_index,
  input  logic [1:0]                  f_state,
  input  logic                        writeback_block,
  output logic [2*NUM_PROC-1:0]       state_table,
  output logic                        wb_valid,
  output logic [$clog2(NUM_PROC)-1:0] wb_proc,
  input  logic                        wb_ready,
  output logic                        done,
  output logic                        protocol_error
);

  localparam int PW = $clog2(NUM_PROC);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_PROC - 1);

  bus_fsm_t              r_state, w_state_nx;
  logic [2:0]            r_bus;
  logic [PW-1:0]         r_proc, r_idx, r_owner;
  logic [1:0]            r_fstate;
  logic                  r_wbblk, r_remote_wb, r_excl_seen, r_perr;
  logic [2*NUM_PROC-1:0] r_table;

  logic [1:0] w_remote, w_next;
  logic       w_needs_wb, w_illegal, w_snoop_upd, w_hit_wb, w_excl, w_remote_wb_nx;

  assign w_remote       = r_table[{r_idx, 1'b0} +: 2];
  assign w_snoop_upd    = (r_state == FSM_SNOOP) && (r_idx != r_proc);
  assign w_hit_wb       = w_snoop_upd && w_needs_wb;
  assign w_excl         = w_snoop_upd && (w_remote == STATE_EXCLUSIVE);
  assign w_remote_wb_nx = r_remote_wb | w_hit_wb;

  snoop_next_state u_next (
    .i_state   (w_remote),
    .i_bus     (r_bus),
    .o_next    (w_next),
    .o_wb      (w_needs_wb),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= FSM_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      FSM_IDLE: begin
        if (req_valid) w_state_nx = (bus == BUS_NONE) ? FSM_COMMIT : FSM_SNOOP;
      end
      FSM_SNOOP: begin
        if (r_idx == LAST_IDX) begin
          if (w_remote_wb_nx)  w_state_nx = FSM_WB_REMOTE;
          else if (r_wbblk)    w_state_nx = FSM_WB_REQ;
          else                 w_state_nx = FSM_COMMIT;
        end
      end
      FSM_WB_REMOTE: begin
        if (wb_ready) w_state_nx = r_wbblk ? FSM_WB_REQ : FSM_COMMIT;
      end
      FSM_WB_REQ: begin
        if (wb_ready) w_state_nx = FSM_COMMIT;
      end
      FSM_COMMIT: w_state_nx = FSM_IDLE;
      default:    w_state_nx = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bus       <= BUS_NONE;
      r_proc      <= '0;
      r_idx       <= '0;
      r_owner     <= '0;
      r_fstate    <= STATE_INVALID;
      r_wbblk     <= 1'b0;
      r_remote_wb <= 1'b0;
      r_excl_seen <= 1'b0;
      r_perr      <= 1'b0;
      r_table     <= '0;
    end else begin
      case (r_state)
        FSM_IDLE: begin
          if (req_valid) begin
            r_bus       <= bus;
            r_proc      <= processor_index;
            r_fstate    <= f_state;
            r_wbblk     <= writeback_block;
            r_idx       <= '0;
            r_remote_wb <= 1'b0;
            r_excl_seen <= 1'b0;
          end
        end
        FSM_SNOOP: begin
          r_idx <= r_idx + PW'(1);
          if (w_snoop_upd) begin
            r_table[{r_idx, 1'b0} +: 2] <= w_next;
            if (w_excl) r_excl_seen <= 1'b1;
            if ((w_excl && r_excl_seen) || w_illegal) r_perr <= 1'b1;
            if (w_hit_wb) begin
              r_remote_wb <= 1'b1;
              r_owner     <= r_idx;
            end
          end
        end
        FSM_COMMIT: begin
          r_table[{r_proc, 1'b0} +: 2] <= (r_fstate == 2'b11) ? STATE_INVALID : r_fstate;
          if (r_fstate == 2'b11) r_perr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (r_state == FSM_IDLE);
  assign wb_valid       = (r_state == FSM_WB_REMOTE) || (r_state == FSM_WB_REQ);
  assign done           = (r_state == FSM_COMMIT);
  assign wb_proc        = (r_state == FSM_WB_REMOTE) ? r_owner :
                          (r_state == FSM_WB_REQ)    ? r_proc  : '0;
  assign state_table    = r_table;
  assign protocol_error = r_perr;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// tb/tb_snoop_bus_controller.sv - directed self-checking bench for snoop_bus_controller
module tb_snoop_bus_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] bus;
  logic [1:0] processor_index;
  logic [1:0] f_state;
  logic       writeback_block;
  logic [7:0] state_table;
  logic       wb_valid;
  logic [1:0] wb_proc;
  logic       wb_ready;
  logic       done;
  logic       protocol_error;

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  snoop_bus_controller #(.NUM_PROC(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .bus             (bus),
    .processor_index (processor_index),
    .f_state         (f_state),
    .writeback_block (writeback_block),
    .state_table     (state_table),
    .wb_valid        (wb_valid),
    .wb_proc         (wb_proc),
    .wb_ready        (wb_ready),
    .done            (done),
    .protocol_error  (protocol_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request from a negedge; returns cycles from acceptance to done,
  // the number of writebacks and the first two wb_proc values. Ends one cycle after done.
  task automatic run(input logic [2:0] b, input logic [1:0] p, input logic [1:0] f,
                     input logic wbb, input int low, output int lat, output int nwb,
                     output logic [1:0] wbp0, output logic [1:0] wbp1);
    int rem;
    bus = b; processor_index = p; f_state = f; writeback_block = wbb; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0; nwb = 0; wbp0 = 2'b00; wbp1 = 2'b00; rem = low;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (done) break;
      if (wb_valid) begin
        if (rem > 0) begin
          wb_ready = 1'b0;
          rem--;
        end else begin
          wb_ready = 1'b1;
          if (nwb == 0) wbp0 = wb_proc;
          else          wbp1 = wb_proc;
          nwb++;
          rem = low;
        end
      end else begin
        wb_ready = 1'b0;
      end
    end
    wb_ready = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int lat, nwb, cyc;
    logic [1:0] p0, p1;
    logic saw_done;

    reset_n = 1'b0; req_valid = 1'b0; bus = 3'b000; processor_index = 2'b00;
    f_state = 2'b00; writeback_block = 1'b0; wb_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    check("rst_req_ready", req_ready, 1);
    check("rst_table", state_table, 8'h00);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_proc", wb_proc, 0);
    check("rst_done", done, 0);
    check("rst_perr", protocol_error, 0);

    // Bus none: commit one cycle after acceptance
    run(3'b000, 2'd2, 2'b01, 1'b0, 0, lat, nwb, p0, p1);
    check("none_latency", lat, 1);
    check("none_table", state_table, 8'h10);
    check("none_req_ready", req_ready, 1);

    // Invalidate with two shared copies
    run(3'b000, 2'd0, 2'b01, 1'b0, 0, lat, nwb, p0, p1);
    run(3'b000, 2'd1, 2'b01, 1'b0, 0, lat, nwb, p0, p1);
    check("setup_shared", state_table, 8'h15);
    run(3'b011, 2'd0, 2'b10, 1'b0, 0, lat, nwb, p0, p1);
    check("inv_latency", lat, 5);
    check("inv_no_wb", nwb, 0);
    check("inv_table", state_table, 8'h02);

    // Read miss against exclusive p3, wb_ready low for two WB cycles
    run(3'b000, 2'd0, 2'b00, 1'b0, 0, lat, nwb, p0, p1);
    run(3'b000, 2'd3, 2'b10, 1'b0, 0, lat, nwb, p0, p1);
    check("setup_p3_excl", state_table, 8'h80);
    run(3'b001, 2'd1, 2'b01, 1'b0, 2, lat, nwb, p0, p1);
    check("rm_latency", lat, 8);
    check("rm_nwb", nwb, 1);
    check("rm_wb_proc", p0, 2'd3);
    check("rm_table", state_table, 8'h44);
    check("rm_perr", protocol_error, 0);

    // Write miss with remote and requester writebacks
    run(3'b000, 2'd2, 2'b10, 1'b0, 0, lat, nwb, p0, p1);
    check("setup_p2_excl", state_table, 8'h64);
    run(3'b010, 2'd0, 2'b10, 1'b1, 0, lat, nwb, p0, p1);
    check("wm_latency", lat, 7);
    check("wm_nwb", nwb, 2);
    check("wm_first_wb", p0, 2'd2);
    check("wm_second_wb", p1, 2'd0);
    check("wm_table", state_table, 8'h02);

    // Invalidate while a remote holds exclusive is illegal; flag is sticky
    run(3'b000, 2'd1, 2'b10, 1'b0, 0, lat, nwb, p0, p1);
    check("setup_p1_excl", state_table, 8'h0A);
    run(3'b011, 2'd0, 2'b10, 1'b0, 0, lat, nwb, p0, p1);
    check("ill_latency", lat, 5);
    check("ill_perr", protocol_error, 1);
    check("ill_table", state_table, 8'h02);
    run(3'b000, 2'd3, 2'b01, 1'b0, 0, lat, nwb, p0, p1);
    check("sticky_perr", protocol_error, 1);
    check("sticky_table", state_table, 8'h42);

    // Reset during WB_REMOTE aborts the transaction
    run(3'b000, 2'd2, 2'b10, 1'b0, 0, lat, nwb, p0, p1);
    check("setup_abort", state_table, 8'h62);
    bus = 3'b001; processor_index = 2'd0; f_state = 2'b01; writeback_block = 1'b0;
    req_valid = 1'b1; wb_ready = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (wb_valid) break;
    end
    check("abort_wb_cycle", cyc, 5);
    check("abort_wb_proc", wb_proc, 2'd2);
    reset_n = 1'b0;
    #1;
    check("abort_wb_valid", wb_valid, 0);
    check("abort_table", state_table, 8'h00);
    check("abort_perr", protocol_error, 0);
    check("abort_done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_idle", req_ready, 1);

    // Final state 11 is illegal and commits invalid
    run(3'b000, 2'd1, 2'b11, 1'b0, 0, lat, nwb, p0, p1);
    check("f11_latency", lat, 1);
    check("f11_perr", protocol_error, 1);
    check("f11_table", state_table, 8'h00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
